// File: rtl/rtl_ral_arb.sv
// Two-requester arbiter/sequencer in front of the 8x8 register bank.
// Define RAL_ARB_FIXED_PRIO_EN for fixed A-over-B priority (default: round-robin).
module rtl_ral_arb #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] add_a_i,
  input  logic [DATA_W-1:0] dt_a_i,
  output logic              gnt_a_o,
  output logic              rvalid_a_o,
  output logic [DATA_W-1:0] dt_a_o,
  input  logic              req_b_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] add_b_i,
  input  logic [DATA_W-1:0] dt_b_i,
  output logic              gnt_b_o,
  output logic              rvalid_b_o,
  output logic [DATA_W-1:0] dt_b_o,
  output logic [ADDR_W-1:0] bank_add_o,
  output logic [DATA_W-1:0] bank_dt_o,
  output logic              bank_rw_o,
  input  logic [DATA_W-1:0] bank_dt_i
);

  // state | meaning
  // IDLE  | waiting for a request; bank sees harmless reads
  // ISSUE | command on bank ports, grant pulse to owner
  // RDATA | bank read data valid, captured for owner
  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t state;
  logic   owner;   // 0 = A, 1 = B
  logic   pick_b;

`ifdef RAL_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_b = req_b_i & ~req_a_i;
  end
`else
  logic last;      // requester served most recently, 0 = A, 1 = B

  always_comb begin
    pick_b = req_b_i & (~req_a_i | ~last);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
`ifndef RAL_ARB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
      gnt_a_o    <= 1'b0;
      gnt_b_o    <= 1'b0;
      rvalid_a_o <= 1'b0;
      rvalid_b_o <= 1'b0;
      dt_a_o     <= '0;
      dt_b_o     <= '0;
      bank_add_o <= '0;
      bank_dt_o  <= '0;
      bank_rw_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rvalid_a_o <= 1'b0;
          rvalid_b_o <= 1'b0;
          if (req_a_i || req_b_i) begin
            owner      <= pick_b;
            gnt_a_o    <= ~pick_b;
            gnt_b_o    <= pick_b;
            bank_rw_o  <= pick_b ? we_b_i  : we_a_i;
            bank_add_o <= pick_b ? add_b_i : add_a_i;
            bank_dt_o  <= pick_b ? dt_b_i  : dt_a_i;
            state      <= ISSUE;
          end else begin
            bank_rw_o <= 1'b0;
          end
        end
        ISSUE: begin
          gnt_a_o <= 1'b0;
          gnt_b_o <= 1'b0;
`ifndef RAL_ARB_FIXED_PRIO_EN
          last    <= owner;
`endif
          // writes complete on this edge; reads need one more cycle for bank data
          if (bank_rw_o) begin
            bank_rw_o <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= RDATA;
          end
        end
        RDATA: begin
          if (owner) begin
            dt_b_o     <= bank_dt_i;
            rvalid_b_o <= 1'b1;
          end else begin
            dt_a_o     <= bank_dt_i;
            rvalid_a_o <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
